multicycle_control_unit: RTL and testbench

Moore-style FSM controller for the multicycle computer. It sits directly downstream of instruction_register and consumes its 4-bit opcode. It sequences fetch/decode/execute/memory/writeback by driving the enables and selects for the PC, the IR, memory, the ALU and the register file. It also carries a memory-wait watchdog and a retired-instruction counter.

---
 rtl/multicycle_control_unit.sv | 328 ++++++++++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
// Moore-style sequencer for the multicycle computer. It walks every
// instruction through fetch / decode / execute / memory / writeback and
// drives the PC, IR, memory, ALU and register-file controls. It also
// carries a memory-wait watchdog and a retired-instruction counter.
//
// Ports:
//   clk            rising-edge system clock
//   reset          asynchronous active-low reset (0 = reset)
//   opcode         4-bit opcode from instruction_register (valid from DECODE on)
//   alu_zero       ALU result == 0, gates the branch PC load
//   mem_ready      memory access completes this cycle
//   pc_enable      PC load (the BRANCH term is the only Mealy output)
//   pc_src         0 = PC+1, 1 = immediate
//   ir_enable      instruction_register load
//   mem_read       memory read strobe
//   mem_write      memory write strobe
//   mem_addr_sel   0 = PC, 1 = ALU result
//   mdr_enable     memory data register load
//   alu_op         0 ADD, 1 SUB, 2 AND, 3 OR
//   alu_src_b      0 = register operand, 1 = zero-extended immediate
//   reg_write      register file write enable
//   wb_sel         0 = ALU result, 1 = MDR
//   halted         FSM is in HALT
//   illegal_op     sticky, undefined opcode or state encoding seen
//   mem_fault      sticky, memory-wait watchdog expired
//   retired_count  completed instructions, wraps
//   state_dbg      current state encoding
module multicycle_control_unit #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       opcode,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             pc_enable,
  output logic             pc_src,
  output logic             ir_enable,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_addr_sel,
  output logic             mdr_enable,
  output logic [2:0]       alu_op,
  output logic             alu_src_b,
  output logic             reg_write,
  output logic             wb_sel,
  output logic             halted,
  output logic             illegal_op,
  output logic             mem_fault,
  output logic [CNT_W-1:0] retired_count,
  output logic [3:0]       state_dbg
);

  typedef enum logic [3:0] {
    S_INIT     = 4'd0,
    S_FETCH    = 4'd1,
    S_LATCH    = 4'd2,
    S_DECODE   = 4'd3,
    S_EXEC_R   = 4'd4,
    S_EXEC_I   = 4'd5,
    S_WB_ALU   = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_WB_MEM   = 4'd9,
    S_MEM_WR   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_HALT     = 4'd13
  } state_t;

  // The watchdog faults on the MEM_TIMEOUT-th consecutive wait cycle, i.e.
  // when the count of waits already seen equals MEM_TIMEOUT-1.
  localparam logic [15:0]      WD_LIMIT = 16'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           next_state_s;
  logic [15:0]      wd_cnt_r;
  logic [CNT_W-1:0] retired_r;
  logic             illegal_r;
  logic             fault_r;

  logic             set_illegal_s;
  logic             set_fault_s;
  logic             retire_s;
  logic             wait_timeout_s;
  logic             in_wait_s;
  logic             enter_wait_s;
  logic [2:0]       r_alu_op_s;

  // Registered Moore outputs
  logic             pc_enable_r, pc_src_r, ir_enable_r, mem_read_r, mem_write_r;
  logic             mem_addr_sel_r, mdr_enable_r, alu_src_b_r, reg_write_r;
  logic             wb_sel_r, halted_r;
  logic [2:0]       alu_op_r;

  // Next values of the registered outputs
  logic             pc_enable_nx, pc_src_nx, ir_enable_nx, mem_read_nx, mem_write_nx;
  logic             mem_addr_sel_nx, mdr_enable_nx, alu_src_b_nx, reg_write_nx;
  logic             wb_sel_nx, halted_nx;
  logic [2:0]       alu_op_nx;

  assign in_wait_s      = (state_r == S_FETCH) || (state_r == S_MEM_RD) || (state_r == S_MEM_WR);
  assign wait_timeout_s = !mem_ready && (wd_cnt_r == WD_LIMIT);
  assign enter_wait_s   = (next_state_s != state_r) &&
                          ((next_state_s == S_FETCH) || (next_state_s == S_MEM_RD) ||
                           (next_state_s == S_MEM_WR));

  // Register-register ALU op: opcodes 1..4 map onto alu_op 0..3
  always_comb begin
    case (opcode)
      4'd1:    r_alu_op_s = 3'd0;
      4'd2:    r_alu_op_s = 3'd1;
      4'd3:    r_alu_op_s = 3'd2;
      default: r_alu_op_s = 3'd3;
    endcase
  end

  // Next-state logic plus sticky-flag and retirement events
  always_comb begin
    next_state_s  = state_r;
    set_illegal_s = 1'b0;
    set_fault_s   = 1'b0;
    retire_s      = 1'b0;
    case (state_r)
      S_INIT: next_state_s = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          next_state_s = S_LATCH;
        end else if (wait_timeout_s) begin
          next_state_s = S_HALT;
          set_fault_s  = 1'b1;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_LATCH: next_state_s = S_DECODE;
      S_DECODE: begin
        case (opcode)
          4'h0: begin
            next_state_s = S_FETCH;
            retire_s     = 1'b1;
          end
          4'h1, 4'h2, 4'h3, 4'h4: next_state_s = S_EXEC_R;
          4'h5:                   next_state_s = S_EXEC_I;
          4'h6, 4'h7:             next_state_s = S_MEM_ADDR;
          4'h8:                   next_state_s = S_BRANCH;
          4'h9:                   next_state_s = S_JUMP;
          4'hF:                   next_state_s = S_HALT;
          default: begin
            next_state_s  = S_HALT;
            set_illegal_s = 1'b1;
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I: next_state_s = S_WB_ALU;
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: begin
        next_state_s = S_FETCH;
        retire_s     = 1'b1;
      end
      S_MEM_ADDR: begin
        if (opcode == 4'h6) begin
          next_state_s = S_MEM_RD;
        end else begin
          next_state_s = S_MEM_WR;
        end
      end
      S_MEM_RD: begin
        if (mem_ready) begin
          next_state_s = S_WB_MEM;
        end else if (wait_timeout_s) begin
          next_state_s = S_HALT;
          set_fault_s  = 1'b1;
        end else begin
          next_state_s = S_MEM_RD;
        end
      end
      S_MEM_WR: begin
        if (mem_ready) begin
          next_state_s = S_FETCH;
          retire_s     = 1'b1;
        end else if (wait_timeout_s) begin
          next_state_s = S_HALT;
          set_fault_s  = 1'b1;
        end else begin
          next_state_s = S_MEM_WR;
        end
      end
      S_HALT: next_state_s = S_HALT;
      default: begin
        // Unused encodings recover into HALT and are flagged
        next_state_s  = S_HALT;
        set_illegal_s = 1'b1;
      end
    endcase
  end

  // Output decode of the state being entered, so outputs register with it
  always_comb begin
    pc_enable_nx    = 1'b0;
    pc_src_nx       = 1'b0;
    ir_enable_nx    = 1'b0;
    mem_read_nx     = 1'b0;
    mem_write_nx    = 1'b0;
    mem_addr_sel_nx = 1'b0;
    mdr_enable_nx   = 1'b0;
    alu_op_nx       = 3'd0;
    alu_src_b_nx    = 1'b0;
    reg_write_nx    = 1'b0;
    wb_sel_nx       = 1'b0;
    halted_nx       = 1'b0;
    case (next_state_s)
      S_FETCH: mem_read_nx = 1'b1;
      S_LATCH: begin
        mem_read_nx  = 1'b1;
        ir_enable_nx = 1'b1;
        pc_enable_nx = 1'b1;
      end
      S_EXEC_R: alu_op_nx = r_alu_op_s;
      S_EXEC_I, S_MEM_ADDR: alu_src_b_nx = 1'b1;
      S_WB_ALU: begin
        // ALU controls carry over from the execute state
        reg_write_nx = 1'b1;
        alu_op_nx    = alu_op_r;
        alu_src_b_nx = alu_src_b_r;
      end
      S_MEM_RD: begin
        mem_read_nx     = 1'b1;
        mem_addr_sel_nx = 1'b1;
        mdr_enable_nx   = 1'b1;
        alu_op_nx       = alu_op_r;
        alu_src_b_nx    = alu_src_b_r;
      end
      S_WB_MEM: begin
        reg_write_nx = 1'b1;
        wb_sel_nx    = 1'b1;
      end
      S_MEM_WR: begin
        mem_write_nx    = 1'b1;
        mem_addr_sel_nx = 1'b1;
        alu_op_nx       = alu_op_r;
        alu_src_b_nx    = alu_src_b_r;
      end
      S_BRANCH: begin
        alu_op_nx = 3'd1;
        pc_src_nx = 1'b1;
      end
      S_JUMP: begin
        pc_enable_nx = 1'b1;
        pc_src_nx    = 1'b1;
      end
      S_HALT:  halted_nx = 1'b1;
      default: halted_nx = 1'b0;
    endcase
  end

  // State, watchdog, counter, sticky flags and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= S_INIT;
      wd_cnt_r       <= 16'd0;
      retired_r      <= {CNT_W{1'b0}};
      illegal_r      <= 1'b0;
      fault_r        <= 1'b0;
      pc_enable_r    <= 1'b0;
      pc_src_r       <= 1'b0;
      ir_enable_r    <= 1'b0;
      mem_read_r     <= 1'b0;
      mem_write_r    <= 1'b0;
      mem_addr_sel_r <= 1'b0;
      mdr_enable_r   <= 1'b0;
      alu_op_r       <= 3'd0;
      alu_src_b_r    <= 1'b0;
      reg_write_r    <= 1'b0;
      wb_sel_r       <= 1'b0;
      halted_r       <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (enter_wait_s) begin
        wd_cnt_r <= 16'd0;
      end else if (in_wait_s && !mem_ready) begin
        wd_cnt_r <= wd_cnt_r + 16'd1;
      end else begin
        wd_cnt_r <= wd_cnt_r;
      end
      if (retire_s) begin
        retired_r <= retired_r + CNT_ONE;
      end else begin
        retired_r <= retired_r;
      end
      illegal_r      <= illegal_r | set_illegal_s;
      fault_r        <= fault_r | set_fault_s;
      pc_enable_r    <= pc_enable_nx;
      pc_src_r       <= pc_src_nx;
      ir_enable_r    <= ir_enable_nx;
      mem_read_r     <= mem_read_nx;
      mem_write_r    <= mem_write_nx;
      mem_addr_sel_r <= mem_addr_sel_nx;
      mdr_enable_r   <= mdr_enable_nx;
      alu_op_r       <= alu_op_nx;
      alu_src_b_r    <= alu_src_b_nx;
      reg_write_r    <= reg_write_nx;
      wb_sel_r       <= wb_sel_nx;
      halted_r       <= halted_nx;
    end
  end

  // Branch PC load follows alu_zero combinationally while in BRANCH
  assign pc_enable     = pc_enable_r | ((state_r == S_BRANCH) & alu_zero);
  assign pc_src        = pc_src_r;
  assign ir_enable     = ir_enable_r;
  assign mem_read      = mem_read_r;
  assign mem_write     = mem_write_r;
  assign mem_addr_sel  = mem_addr_sel_r;
  assign mdr_enable    = mdr_enable_r;
  assign alu_op        = alu_op_r;
  assign alu_src_b     = alu_src_b_r;
  assign reg_write     = reg_write_r;
  assign wb_sel        = wb_sel_r;
  assign halted        = halted_r;
  assign illegal_op    = illegal_r;
  assign mem_fault     = fault_r;
  assign retired_count = retired_r;
  assign state_dbg     = state_r;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit. The stimulus side expands
// each instruction into its per-cycle control pattern from the opcode's
// phase list and pushes it into a queue; a negedge monitor pops and compares.
module tb_multicycle_control_unit;
  localparam int MEM_TO = 4;
  localparam int CW     = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    opcode;
  logic          alu_zero;
  logic          mem_ready;
  logic          pc_enable, pc_src, ir_enable, mem_read, mem_write;
  logic          mem_addr_sel, mdr_enable, alu_src_b, reg_write, wb_sel;
  logic          halted, illegal_op, mem_fault;
  logic [2:0]    alu_op;
  logic [CW-1:0] retired_count;
  logic [3:0]    state_dbg;

  always #5 clk = ~clk;

  multicycle_control_unit #(.MEM_TIMEOUT(MEM_TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .pc_enable(pc_enable), .pc_src(pc_src),
    .ir_enable(ir_enable), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr_sel(mem_addr_sel), .mdr_enable(mdr_enable), .alu_op(alu_op),
    .alu_src_b(alu_src_b), .reg_write(reg_write), .wb_sel(wb_sel),
    .halted(halted), .illegal_op(illegal_op), .mem_fault(mem_fault),
    .retired_count(retired_count), .state_dbg(state_dbg)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pc_en, pc_src, ir_en, mrd, mwr, masel, mdr;
    logic [2:0] aop;
    logic       srcb, rw, wbs, hlt, ill, flt;
    logic [3:0] ret;
  } vec_t;

  vec_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   m_ret  = 0;
  bit   m_ill  = 1'b0;
  bit   m_flt  = 1'b0;

  function automatic vec_t actual();
    vec_t a;
    a.st = state_dbg; a.pc_en = pc_enable; a.pc_src = pc_src; a.ir_en = ir_enable;
    a.mrd = mem_read; a.mwr = mem_write; a.masel = mem_addr_sel; a.mdr = mdr_enable;
    a.aop = alu_op; a.srcb = alu_src_b; a.rw = reg_write; a.wbs = wb_sel;
    a.hlt = halted; a.ill = illegal_op; a.flt = mem_fault; a.ret = retired_count;
    return a;
  endfunction

  function automatic vec_t base(input logic [3:0] st);
    vec_t v;
    v = '0;
    v.st = st; v.ill = m_ill; v.flt = m_flt; v.ret = 4'(m_ret);
    return v;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void bump();
    m_ret = (m_ret + 1) % (1 << CW);
  endfunction

  // Monitor: compare every cycle for which an expectation is queued
  always @(negedge clk) begin
    vec_t e, a;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      a = actual();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL ctrl_vec t=%0t state got %0d want %0d: got %h want %h",
                 $time, a.st, e.st, a, e);
      end
    end
  end

  task automatic cyc(input vec_t v, input logic mr, input logic az);
    mem_ready = mr;
    alu_zero  = az;
    sbq.push_back(v);
    @(posedge clk);
    #1;
  endtask

  // A memory-wait phase: `waits` cycles with mem_ready low, then completion,
  // unless the watchdog limit is hit first.
  task automatic waitph(input vec_t v, input int waits, output bit f);
    f = 1'b0;
    for (int i = 0; i < waits && !f; i++) begin
      cyc(v, 1'b0, rbit());
      if (i + 1 == MEM_TO) begin
        m_flt = 1'b1;
        f     = 1'b1;
      end
    end
    if (!f) cyc(v, 1'b1, rbit());
  endtask

  task automatic halt_cycles(input int n);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v = base(4'd13);
      v.hlt = 1'b1;
      cyc(v, (i == 0) ? 1'b1 : rbit(), rbit());
    end
  endtask

  // Assert reset between edges and check that outputs clear at once
  task automatic do_reset();
    vec_t a;
    #2;
    reset = 1'b0;
    #1;
    a = actual();
    checks++;
    if (a !== '0) begin
      errors++;
      $display("FAIL async_reset got %h want 0", a);
    end
    m_ret = 0; m_ill = 1'b0; m_flt = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc(base(4'd0), rbit(), rbit());
  endtask

  task automatic run_instr(input logic [3:0] op, input int wf, input int wm,
                           input logic az, output bit stopped);
    vec_t v;
    bit   f;
    stopped = 1'b0;
    opcode  = op;
    v = base(4'd1); v.mrd = 1'b1;
    waitph(v, wf, f);
    if (f) begin
      halt_cycles(3);
      stopped = 1'b1;
      return;
    end
    v = base(4'd2); v.mrd = 1'b1; v.ir_en = 1'b1; v.pc_en = 1'b1;
    cyc(v, rbit(), rbit());
    cyc(base(4'd3), rbit(), rbit());
    case (op)
      4'h0: bump();
      4'h1, 4'h2, 4'h3, 4'h4: begin
        v = base(4'd4); v.aop = 3'(op - 4'd1);
        cyc(v, rbit(), rbit());
        v = base(4'd6); v.aop = 3'(op - 4'd1); v.rw = 1'b1;
        cyc(v, rbit(), rbit());
        bump();
      end
      4'h5: begin
        v = base(4'd5); v.srcb = 1'b1;
        cyc(v, rbit(), rbit());
        v = base(4'd6); v.srcb = 1'b1; v.rw = 1'b1;
        cyc(v, rbit(), rbit());
        bump();
      end
      4'h6, 4'h7: begin
        v = base(4'd7); v.srcb = 1'b1;
        cyc(v, rbit(), rbit());
        if (op == 4'h6) begin
          v = base(4'd8); v.mrd = 1'b1; v.masel = 1'b1; v.mdr = 1'b1; v.srcb = 1'b1;
        end else begin
          v = base(4'd10); v.mwr = 1'b1; v.masel = 1'b1; v.srcb = 1'b1;
        end
        waitph(v, wm, f);
        if (f) begin
          halt_cycles(3);
          stopped = 1'b1;
        end else if (op == 4'h6) begin
          v = base(4'd9); v.rw = 1'b1; v.wbs = 1'b1;
          cyc(v, rbit(), rbit());
          bump();
        end else begin
          bump();
        end
      end
      4'h8: begin
        v = base(4'd11); v.aop = 3'd1; v.pc_src = 1'b1; v.pc_en = az;
        cyc(v, rbit(), az);
        bump();
      end
      4'h9: begin
        v = base(4'd12); v.pc_en = 1'b1; v.pc_src = 1'b1;
        cyc(v, rbit(), rbit());
        bump();
      end
      4'hF: begin
        halt_cycles(3);
        stopped = 1'b1;
      end
      default: begin
        m_ill = 1'b1;
        halt_cycles(3);
        stopped = 1'b1;
      end
    endcase
  endtask

  initial begin
    bit s;
    logic [3:0] rop;
    reset = 1'b0; opcode = 4'd0; alu_zero = 1'b0; mem_ready = 1'b0;
    do_reset();

    // Directed: ADD, LOAD with 3 waits, BEQ taken / not taken
    run_instr(4'h1, 0, 0, 1'b0, s);
    run_instr(4'h6, 0, 3, 1'b0, s);
    run_instr(4'h8, 0, 0, 1'b1, s);
    run_instr(4'h8, 0, 0, 1'b0, s);
    run_instr(4'h7, 1, 2, 1'b0, s);
    run_instr(4'h9, 0, 0, 1'b0, s);
    run_instr(4'h5, 3, 0, 1'b0, s);
    run_instr(4'h2, 0, 0, 1'b0, s);
    run_instr(4'h3, 0, 0, 1'b0, s);
    run_instr(4'h4, 0, 0, 1'b0, s);
    run_instr(4'h0, 0, 0, 1'b0, s);

    // Random legal program, waits always below the watchdog limit
    for (int i = 0; i < 60; i++) begin
      rop = 4'($urandom_range(0, 9));
      run_instr(rop, $urandom_range(0, 3), $urandom_range(0, 3), rbit(), s);
    end

    // Counter wrap: 17 NOPs after reset, count goes 15 -> 0 -> 1
    do_reset();
    for (int i = 0; i < 17; i++) run_instr(4'h0, 0, 0, 1'b0, s);

    // Watchdog expiry in each wait state
    do_reset();
    run_instr(4'h0, 4, 0, 1'b0, s);
    do_reset();
    run_instr(4'h6, 0, 4, 1'b0, s);
    do_reset();
    run_instr(4'h7, 2, 4, 1'b0, s);

    // Illegal opcode, then HALT opcode, each cleared by async reset
    do_reset();
    run_instr(4'h1, 0, 0, 1'b0, s);
    run_instr(4'hB, 0, 0, 1'b0, s);
    do_reset();
    run_instr(4'hF, 0, 0, 1'b0, s);
    do_reset();
    run_instr(4'h6, 1, 1, 1'b0, s);

    repeat (3) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
